// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transmit scheduler: FSM state encoding,
// parameter defaults and small index helpers.
package spi_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int DW_DEF      = 6;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : spi_pkg

// File: rtl/spi_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ...
// wrapping modulo NREQ. Produces a one-hot grant, its index and an any flag.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_winner,
  output logic            o_any
);

  logic          w_found;
  int            w_sum;
  logic [PW-1:0] w_idx;

  // NOTE: every signal written here gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = 0;
    w_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= NREQ) begin
        w_sum = w_sum - NREQ;
      end
      w_idx = PW'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_winner        = w_idx;
      end
    end
  end

  assign o_any = |i_req;

endmodule : rr_arbiter

// File: rtl/spi_tx_sched.sv
// Shares one serial transmit engine among NREQ requesters: round-robin grant,
// start pulse, bounded wait for the engine's done pulse, then ack (with err on abort).
module spi_tx_sched
  import spi_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               tx_start,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_done
);

  localparam int PW = ptr_width(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_winner;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic              r_err;
  logic              r_tx_start;
  logic [DW-1:0]     r_tx_data;

  state_t            w_state_nx;
  logic [PW-1:0]     w_ptr_nx;
  logic [PW-1:0]     w_winner_nx;
  logic [CW-1:0]     w_cnt_nx;
  logic [NREQ-1:0]   w_gnt_nx;
  logic [NREQ-1:0]   w_ack_nx;
  logic              w_err_nx;
  logic              w_tx_start_nx;
  logic [DW-1:0]     w_tx_data_nx;

  logic [NREQ-1:0]   w_grant;
  logic [PW-1:0]     w_winner;
  logic              w_any;
  logic [DW-1:0]     w_sel_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // The grant is one-hot, so OR-ing the masked words yields the winner's word.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_data = w_sel_data | req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_ptr_nx      = r_ptr;
    w_winner_nx   = r_winner;
    w_cnt_nx      = r_cnt;
    w_gnt_nx      = r_gnt;
    w_ack_nx      = '0;
    w_err_nx      = 1'b0;
    w_tx_start_nx = 1'b0;
    w_tx_data_nx  = r_tx_data;

    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx    = S_START;
          w_gnt_nx      = w_grant;
          w_winner_nx   = w_winner;
          w_tx_data_nx  = w_sel_data;
          w_tx_start_nx = 1'b1;
        end
      end

      S_START: begin
        w_state_nx = S_WAIT;
        w_cnt_nx   = '0;
      end

      // tx_done wins over the timeout when both land in the same cycle.
      S_WAIT: begin
        w_cnt_nx = r_cnt + CW'(1);
        if (tx_done) begin
          w_state_nx = S_DONE;
          w_ack_nx   = r_gnt;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nx = S_DONE;
          w_ack_nx   = r_gnt;
          w_err_nx   = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
        w_ptr_nx   = PW'(rr_next(int'(r_winner), NREQ));
      end

      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_winner   <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_winner   <= w_winner_nx;
      r_cnt      <= w_cnt_nx;
      r_gnt      <= w_gnt_nx;
      r_ack      <= w_ack_nx;
      r_err      <= w_err_nx;
      r_tx_start <= w_tx_start_nx;
      r_tx_data  <= w_tx_data_nx;
    end
  end

  assign gnt      = r_gnt;
  assign ack      = r_ack;
  assign err      = r_err;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule : spi_tx_sched

// File: tb/tb_spi_tx_sched.sv
// Directed bench for spi_tx_sched: a table of transfers with hand-computed
// grants, data, ack latency and err, plus sequences for stray done, data churn and reset.
module tb_spi_tx_sched;

  localparam int NREQ    = 4;
  localparam int DW      = 6;
  localparam int TIMEOUT = 64;
  localparam logic [NREQ*DW-1:0] FIXED_DATA = {6'h33, 6'h2A, 6'h22, 6'h11};

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic               tx_start;
  logic [DW-1:0]      tx_data;
  logic               tx_done;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int last_start = -1;

  spi_tx_sched #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] req;
    int              dly;      // cycles after tx_start for tx_done; -1 = never
    logic [NREQ-1:0] exp_gnt;
    logic [DW-1:0]   exp_data;
    logic            exp_err;
    int              exp_lat;  // cycles from tx_start to ack
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_txn(input string name, input logic [NREQ-1:0] r, input int dly,
                         input logic [NREQ-1:0] eg, input logic [DW-1:0] ed,
                         input logic ee, input int elat, input bit scramble,
                         input bit drop, input int gap_exp);
    int n;
    int s;
    int bad_start;
    int bad_data;
    int bad_gnt;
    int bad_err;
    req = r;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_start && n < 8);
    check({name, " start_lat"}, n, 1);
    check({name, " gnt"}, gnt, eg);
    check({name, " tx_data"}, tx_data, ed);
    if (gap_exp > 0) check({name, " start_gap"}, cyc - last_start, gap_exp);
    last_start = cyc;

    s = 0; bad_start = 0; bad_data = 0; bad_gnt = 0; bad_err = 0;
    while (s < 200) begin
      if (s == dly) tx_done = 1'b1;
      if (scramble) req_data = (NREQ*DW)'($urandom);
      if (drop) req = '0;
      tick();
      tx_done = 1'b0;
      s++;
      if (ack != '0) break;
      if (tx_start) bad_start++;
      if (tx_data !== ed) bad_data++;
      if (gnt !== eg) bad_gnt++;
      if (err) bad_err++;
    end
    check({name, " ack_lat"}, s, elat);
    check({name, " ack"}, ack, eg);
    check({name, " err"}, err, ee);
    check({name, " gnt_done"}, gnt, eg);
    check({name, " data_done"}, tx_data, ed);
    check({name, " wait_quiet"}, bad_start + bad_data + bad_gnt + bad_err, 0);
    if (scramble) req_data = FIXED_DATA;
    tick();
    check({name, " idle_ack"}, ack, '0);
    check({name, " idle_err"}, err, 1'b0);
    check({name, " idle_gnt"}, gnt, '0);
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 14, 4'b0100, 6'h2A, 1'b0, 15};
    tbl[1]  = '{4'b1111, 10, 4'b1000, 6'h33, 1'b0, 11};
    tbl[2]  = '{4'b1111, 10, 4'b0001, 6'h11, 1'b0, 11};
    tbl[3]  = '{4'b1111, 10, 4'b0010, 6'h22, 1'b0, 11};
    tbl[4]  = '{4'b1111, 10, 4'b0100, 6'h2A, 1'b0, 11};
    tbl[5]  = '{4'b1111, 10, 4'b1000, 6'h33, 1'b0, 11};
    tbl[6]  = '{4'b1111, 10, 4'b0001, 6'h11, 1'b0, 11};
    tbl[7]  = '{4'b0001, -1, 4'b0001, 6'h11, 1'b1, 65};
    tbl[8]  = '{4'b0001, 64, 4'b0001, 6'h11, 1'b0, 65};
    tbl[9]  = '{4'b0101, 1,  4'b0100, 6'h2A, 1'b0, 2};
    tbl[10] = '{4'b0101, 0,  4'b0001, 6'h11, 1'b1, 65};
    tbl[11] = '{4'b1010, 63, 4'b0010, 6'h22, 1'b0, 64};
    tbl[12] = '{4'b1010, 5,  4'b1000, 6'h33, 1'b0, 6};

    rst_n    = 1'b0;
    req      = '0;
    tx_done  = 1'b0;
    req_data = FIXED_DATA;
    #1;
    check("rst gnt", gnt, '0);
    check("rst ack", ack, '0);
    check("rst err", err, 1'b0);
    check("rst tx_start", tx_start, 1'b0);
    check("rst tx_data", tx_data, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 13; k++) begin
      run_txn($sformatf("vec%0d", k), tbl[k].req, tbl[k].dly, tbl[k].exp_gnt,
              tbl[k].exp_data, tbl[k].exp_err, tbl[k].exp_lat, 1'b0, 1'b0,
              (k == 0) ? 0 : tbl[k-1].exp_lat + 2);
    end
    req = '0;
    tick();

    // Stray tx_done while idle must not start anything or move the pointer.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("stray gnt", gnt, '0);
    check("stray tx_start", tx_start, 1'b0);
    check("stray ack", ack, '0);
    tick();
    check("stray gnt2", gnt, '0);
    check("stray tx_start2", tx_start, 1'b0);
    run_txn("post_stray", 4'b1100, 2, 4'b0100, 6'h2A, 1'b0, 3, 1'b0, 1'b0, 0);

    // Data churn plus request withdrawn after grant: transfer completes on the latched word.
    run_txn("churn", 4'b0010, 7, 4'b0010, 6'h22, 1'b0, 8, 1'b1, 1'b1, 0);

    // Reset in the middle of WAIT.
    req = 4'b0010;
    tick();
    check("rstw start", tx_start, 1'b1);
    check("rstw gnt", gnt, 4'b0010);
    tick();
    tick();
    tick();
    check("rstw gnt_wait", gnt, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("rstw gnt_drop", gnt, '0);
    check("rstw data_clr", tx_data, '0);
    req = 4'b0011;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("rstw ack_lo1", ack, '0);
    tick();
    check("rstw ack_lo2", ack, '0);
    check("rstw err_lo", err, 1'b0);
    rst_n = 1'b1;
    run_txn("rstw_rr", 4'b0011, 3, 4'b0001, 6'h11, 1'b0, 4, 1'b0, 1'b0, 0);
    req = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spi_tx_sched
